// File: rtl/input_device_port_if.sv
// CPU device-bus read/write signals plus the external sample handshake
// for the memory-mapped input port.
interface input_device_port_if #(
   parameter int DATA_W = 12
);
   logic [31:0]       Address;
   logic              readEn;
   logic              writeEn;
   logic [31:0]       writeData;
   logic [31:0]       readData;
   logic [DATA_W-1:0] in_data;
   logic              in_valid;
   logic              in_ready;

   // Sample handshake: a sample transfers on a rising edge where
   // in_valid and in_ready are both high; in_valid may be held across
   // cycles while in_ready is low.
   modport slave (
      input  Address, readEn, writeEn, writeData, in_data, in_valid,
      output readData, in_ready
   );

   modport master (
      output Address, readEn, writeEn, writeData, in_data, in_valid,
      input  readData, in_ready
   );
endinterface

// File: rtl/input_device_port.sv
// Memory-mapped input peripheral: external samples are queued in a small
// FIFO and popped by CPU loads through a 16-byte register window.
module input_device_port #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_7F10,
   parameter int          DATA_W    = 12,
   parameter int          DEPTH     = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input_device_port_if.slave   bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic              underflow_q, underflow_d;
   logic              enable_q, enable_d;
   logic [31:0]       rdata_q, rdata_d;

   logic       hit;
   logic [1:0] offset;
   logic       rd_acc, ctrl_wr, empty, full, ready;
   logic       push, pop_req, pop, flush;
   logic       unused_bits;

   assign hit     = (bus.Address[31:4] == BASE_ADDR[31:4]);
   assign offset  = bus.Address[3:2];
   // A colliding read and write honours the write and returns nothing.
   assign rd_acc  = bus.readEn & hit & ~bus.writeEn;
   assign ctrl_wr = bus.writeEn & hit & (offset == 2'd2);

   assign empty   = (count_q == '0);
   assign full    = (count_q == FULL_CNT);
   // CTRL write cycles refuse samples so a flush never drops a handshaked one.
   assign ready   = enable_q & ~full & ~ctrl_wr;
   assign bus.in_ready = ready;

   assign push    = bus.in_valid & ready;
   assign pop_req = rd_acc & (offset == 2'd0);
   assign pop     = pop_req & ~empty;
   assign flush   = ctrl_wr & bus.writeData[1];

   assign unused_bits  = ^{bus.writeData[31:3], bus.Address[1:0]};
   assign bus.readData = rdata_q;

   always_comb begin
      rdata_d = '0;
      if (rd_acc) begin
         case (offset)
            2'd0:    if (!empty) rdata_d = 32'(mem_q[rd_ptr_q]);
            2'd1:    rdata_d = 32'({count_q, enable_q, underflow_q, full, ~empty});
            2'd2:    rdata_d = {31'b0, enable_q};
            default: rdata_d = '0;
         endcase
      end
   end

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      enable_d    = enable_q;
      underflow_d = underflow_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
         case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
      if (ctrl_wr) enable_d = bus.writeData[0];
      if (ctrl_wr && bus.writeData[2]) underflow_d = 1'b0;
      else if (pop_req && empty)       underflow_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         underflow_q <= 1'b0;
         enable_q    <= 1'b0;
         rdata_q     <= '0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         underflow_q <= underflow_d;
         enable_q    <= enable_d;
         rdata_q     <= rdata_d;
      end
   end

   // Storage needs no reset: entries are only visible through count_q.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= bus.in_data;
   end
endmodule

// File: doc/input_device_port.md
Name: input_device_port

Overview:
- Memory-mapped input peripheral for the pipelined CPU.
- It covers the read direction of the CPU's device bus: an external source pushes 12-bit samples into an internal FIFO, and the CPU pulls them out with loads.
- It sits beside the output Device on the same Address/writeEn bus, adding readEn and a registered 32-bit read-data return.

Parameters:
- BASE_ADDR, 32'h0000_7F10, base of the 16-byte register window; bits [3:0] must be 0.
- DATA_W, 12, external sample width.
- DEPTH, 4, FIFO entries; must be a power of 2, ≥2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- Address  input  32  CPU byte address.
- readEn  input  1  CPU load strobe, valid for one cycle per access.
- writeEn  input  1  CPU store strobe.
- writeData  input  32  CPU store data.
- readData  output  32  registered load return.
- in_data  input  DATA_W  external sample.
- in_valid  input  1  sample offered.
- in_ready  output  1  port can accept a sample this cycle.

Behaviour:
- Address decode:
  - hit = (Address[31:4] == BASE_ADDR[31:4]).
  - Register offset = Address[3:2]; Address[1:0] is ignored.
- Register map:
  - Offset 0, DATA (read-only): pops the FIFO head, zero-extended to 32 bits.
  - Offset 1, STATUS (read-only):
    - bit0 = not-empty.
    - bit1 = full.
    - bit2 = underflow, sticky.
    - bit3 = enable.
    - bits[4+CW-1:4] = occupancy count, where CW = log2(DEPTH)+1.
    - All other bits are 0.
  - Offset 2, CTRL (read/write):
    - bit0 = enable, readable and writable.
    - bit1 = flush, write-1 pulse; reads as 0.
    - bit2 = clear underflow, write-1 pulse; reads as 0.
  - Offset 3: reads 0; writes are ignored.
- Read latency and data:
  - readData is registered. A read issued in cycle N (readEn & hit) is returned in cycle N+1.
  - readData is 0 in any cycle after a non-hit or non-read cycle.
  - Reads reflect state before any same-cycle update. For example, STATUS read in the same cycle as a push shows the pre-push count.
- Pop:
  - A DATA read with count > 0 returns the head entry, advances the read pointer and decrements count.
  - A DATA read with count = 0 returns 0, leaves pointers unchanged and sets underflow.
- Push:
  - A push occurs when in_valid & in_ready.
  - The sample is written at the write pointer, the write pointer advances and count increments.
  - in_ready = enable & (count != DEPTH) & ~(writeEn & hit & offset==2). CTRL write cycles never accept a sample, so a flush cannot lose a handshaked sample.
- Simultaneous push and pop:
  - With count in 1..DEPTH-1, both occur and count is unchanged.
  - With count = 0, the pop underflows (returns 0) and the push still lands; count becomes 1.
  - With count = DEPTH, the pop occurs and no push occurs, since in_ready is low.
- Pointer arithmetic: log2(DEPTH)-bit pointers wrap modulo DEPTH. count ranges 0..DEPTH.
- Flush: zeroes both pointers and count next edge. A same-cycle DATA read is not possible because there is one access per cycle.
- Writing enable=0 does not flush: stored data stays readable and in_ready drops.
- readEn and writeEn are never asserted together (CPU guarantee). If they are, the write is honoured and readData is 0.
- Reset: on the next edge, sets pointers, count, underflow, enable and readData to 0, so in_ready = 0. Any in-flight sample or pending read return is discarded.

Test Plan:
- Reset, then write CTRL=1 at 0x7F18; in cycle+1 read STATUS at 0x7F14 -> readData = 32'h0000_0008 one cycle after the read; in_ready = 1.
- Push 12'hABC, 12'h123, then read DATA twice -> readData = 32'h0000_0ABC, then 32'h0000_0123; STATUS then = 32'h0000_0008.
- Push 5 samples back-to-back with DEPTH=4 -> in_ready falls after the 4th; STATUS = 32'h0000_004B. The 5th is accepted the cycle after a DATA pop; wrap order is preserved across 3 further push/pop rounds.
- Read DATA while empty -> readData = 0 and STATUS bit2 = 1. Write CTRL=32'h5 -> bit2 clears and enable stays 1.
- With count = 2, in_valid held high while CTRL=32'h3 is written -> in_ready is low that cycle; count = 0 after. The held sample is accepted the following cycle.
- Assert reset with count = 3 and a DATA read in the same cycle -> next cycle readData = 0, in_ready = 0, STATUS = 0.
